// File: rtl/galaga_pkg.sv
// Shared constants and types for the ADC input conditioner: slot numbering,
// data widths, stick direction encoding and the raw-code to millivolt scaling.
package galaga_pkg;

    localparam int SlotCount = 5;
    localparam int BtnCount  = 3;
    localparam int MvWidth   = 13;
    localparam int AdcWidth  = 12;
    localparam int ChWidth   = 5;

    typedef enum logic [2:0] {
        SLOT_X = 3'd0,
        SLOT_B = 3'd1,
        SLOT_A = 3'd2,
        SLOT_J = 3'd3,
        SLOT_Y = 3'd4
    } slot_e;

    localparam logic [1:0] AXIS_CTR = 2'b00;
    localparam logic [1:0] AXIS_POS = 2'b01;
    localparam logic [1:0] AXIS_NEG = 2'b11;

    // 5001/4096 maps full scale 4095 onto 4999 mV and mid-code 2048 onto 2500 mV.
    function automatic logic [MvWidth-1:0] adc_to_mv(input logic [AdcWidth-1:0] code);
        logic [AdcWidth+MvWidth-1:0] prod;
        prod = {{MvWidth{1'b0}}, code} * (AdcWidth + MvWidth)'(5001);
        return prod[AdcWidth+MvWidth-1:AdcWidth];
    endfunction

endpackage

// File: rtl/adc_btn_debounce.sv
// One button: hysteresis on the averaged voltage, then a consecutive-agreement
// debounce counter, producing a level and a one-cycle press pulse.
module adc_btn_debounce
    import galaga_pkg::*;
#(
    parameter int DebounceCount = 4,
    parameter int PressMv       = 1000,
    parameter int ReleaseMv     = 1500
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               pub_i,
    input  logic [MvWidth-1:0] avg_i,
    output logic               level_o,
    output logic               press_o
);

    localparam int                CntW    = $clog2(DebounceCount + 1);
    localparam logic [CntW-1:0]   CntLast = CntW'(DebounceCount - 1);
    localparam logic [MvWidth-1:0] PressTh = MvWidth'(PressMv);
    localparam logic [MvWidth-1:0] RelTh   = MvWidth'(ReleaseMv);

    logic            raw_q, raw_d;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        raw_d   = raw_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        if (pub_i) begin
            // Between the two thresholds the previous raw reading is kept.
            if (avg_i < PressTh) begin
                raw_d = 1'b1;
            end else if (avg_i > RelTh) begin
                raw_d = 1'b0;
            end
            if (raw_d != level_q) begin
                if (cnt_q == CntLast) begin
                    level_d = ~level_q;
                    press_d = ~level_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            raw_q   <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            raw_q   <= raw_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/adc_input_conditioner.sv
// ADC response stream -> per-slot box-averaged millivolts, debounced buttons
// and dead-zoned stick directions. Three-stage pipeline, one sample per cycle.
module adc_input_conditioner
    import galaga_pkg::*;
#(
    parameter int AvgShift      = 2,
    parameter int DebounceCount = 4,
    parameter int PressMv       = 1000,
    parameter int ReleaseMv     = 1500,
    parameter int CenterMv      = 2500,
    parameter int DeadMv        = 400
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               resp_valid_i,
    input  logic [ChWidth-1:0]                 resp_channel_i,
    input  logic [AdcWidth-1:0]                resp_data_i,
    output logic [SlotCount-1:0][MvWidth-1:0]  mv_o,
    output logic [SlotCount-1:0]               ch_valid_o,
    output logic [BtnCount-1:0]                btn_level_o,
    output logic [BtnCount-1:0]                btn_press_o,
    output logic [1:0]                         axis_x_o,
    output logic [1:0]                         axis_y_o
);

    localparam int                 AccW    = MvWidth + AvgShift;
    localparam int                 CntW    = AvgShift + 1;
    localparam logic [CntW-1:0]    WinLast = CntW'((1 << AvgShift) - 1);
    localparam logic [MvWidth-1:0] HiMv    = MvWidth'(CenterMv + DeadMv);
    localparam logic [MvWidth-1:0] LoMv    = MvWidth'(CenterMv - DeadMv);

    // Stage 1: capture, dropping channels outside 1..5.
    logic [1:0]          vld_pipe_q;
    slot_e               s1_slot_q;
    logic [AdcWidth-1:0] s1_data_q;
    logic                ch_ok;
    logic [ChWidth-1:0]  ch_m1;

    assign ch_ok = resp_valid_i && (resp_channel_i >= ChWidth'(1))
                                && (resp_channel_i <= ChWidth'(SlotCount));
    assign ch_m1 = resp_channel_i - ChWidth'(1);

    // Stage 2: scale to millivolts.
    slot_e              s2_slot_q;
    logic [MvWidth-1:0] s2_mv_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            vld_pipe_q <= '0;
            s1_slot_q  <= SLOT_X;
            s1_data_q  <= '0;
            s2_slot_q  <= SLOT_X;
            s2_mv_q    <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[0], ch_ok};
            s1_slot_q  <= slot_e'(ch_m1[2:0]);
            s1_data_q  <= resp_data_i;
            s2_slot_q  <= s1_slot_q;
            s2_mv_q    <= adc_to_mv(s1_data_q);
        end
    end

    // Stage 3: per-slot accumulate and publish on the window-completing sample.
    logic [AccW-1:0]                   acc_q [SlotCount];
    logic [CntW-1:0]                   cnt_q [SlotCount];
    logic [SlotCount-1:0][MvWidth-1:0] mv_q;
    logic [SlotCount-1:0]              chv_q;
    logic [SlotCount-1:0]              pub_q;
    logic [AccW-1:0]                   sum_d;
    logic [MvWidth-1:0]                avg_d;
    logic                              win_done;

    always_comb begin
        sum_d    = acc_q[s2_slot_q] + AccW'(s2_mv_q);
        avg_d    = MvWidth'(sum_d >> AvgShift);
        win_done = (cnt_q[s2_slot_q] == WinLast);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < SlotCount; i++) begin
                acc_q[i] <= '0;
                cnt_q[i] <= '0;
            end
            mv_q  <= '0;
            chv_q <= '0;
            pub_q <= '0;
        end else begin
            pub_q <= '0;
            if (vld_pipe_q[1]) begin
                if (win_done) begin
                    acc_q[s2_slot_q] <= '0;
                    cnt_q[s2_slot_q] <= '0;
                    mv_q[s2_slot_q]  <= avg_d;
                    chv_q[s2_slot_q] <= 1'b1;
                    pub_q[s2_slot_q] <= 1'b1;
                end else begin
                    acc_q[s2_slot_q] <= sum_d;
                    cnt_q[s2_slot_q] <= cnt_q[s2_slot_q] + CntW'(1);
                end
            end
        end
    end

    // Sticks: evaluated one edge after their slot publishes.
    function automatic logic [1:0] axis_dir(input logic [MvWidth-1:0] mv);
        if (mv > HiMv) return AXIS_POS;
        if (mv < LoMv) return AXIS_NEG;
        return AXIS_CTR;
    endfunction

    logic [1:0] axis_x_q, axis_y_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            axis_x_q <= AXIS_CTR;
            axis_y_q <= AXIS_CTR;
        end else begin
            if (pub_q[SLOT_X]) axis_x_q <= axis_dir(mv_q[SLOT_X]);
            if (pub_q[SLOT_Y]) axis_y_q <= axis_dir(mv_q[SLOT_Y]);
        end
    end

    // Buttons B, A, J occupy slots 1..3.
    for (genvar b = 0; b < BtnCount; b++) begin : g_btn
        adc_btn_debounce #(
            .DebounceCount(DebounceCount),
            .PressMv      (PressMv),
            .ReleaseMv    (ReleaseMv)
        ) u_btn (
            .clk_i  (clk_i),
            .reset_i(reset_i),
            .pub_i  (pub_q[b+1]),
            .avg_i  (mv_q[b+1]),
            .level_o(btn_level_o[b]),
            .press_o(btn_press_o[b])
        );
    end

    assign mv_o       = mv_q;
    assign ch_valid_o = chv_q;
    assign axis_x_o   = axis_x_q;
    assign axis_y_o   = axis_y_q;

endmodule

// File: tb/tb_adc_input_conditioner.sv
// Directed stimulus with a due-cycle scoreboard; the monitor checks each queued
// expectation on the falling edge of the cycle it becomes due.
module tb_adc_input_conditioner;
    import galaga_pkg::*;

    logic                              clk_i = 1'b0;
    logic                              reset_i = 1'b1;
    logic                              resp_valid_i = 1'b0;
    logic [ChWidth-1:0]                resp_channel_i = '0;
    logic [AdcWidth-1:0]               resp_data_i = '0;
    logic [SlotCount-1:0][MvWidth-1:0] mv_o;
    logic [SlotCount-1:0]              ch_valid_o;
    logic [BtnCount-1:0]               btn_level_o;
    logic [BtnCount-1:0]               btn_press_o;
    logic [1:0]                        axis_x_o;
    logic [1:0]                        axis_y_o;

    adc_input_conditioner dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .resp_valid_i  (resp_valid_i),
        .resp_channel_i(resp_channel_i),
        .resp_data_i   (resp_data_i),
        .mv_o          (mv_o),
        .ch_valid_o    (ch_valid_o),
        .btn_level_o   (btn_level_o),
        .btn_press_o   (btn_press_o),
        .axis_x_o      (axis_x_o),
        .axis_y_o      (axis_y_o)
    );

    always #5 clk_i = ~clk_i;

    localparam int K_MV = 0, K_CHV = 1, K_AXX = 2, K_AXY = 3, K_LVL = 4, K_PRS = 5, K_ALL0 = 6;

    typedef struct {
        int due;
        int kind;
        int idx;
        int val;
    } chk_t;

    chk_t sb[$];
    int   cyc = 0;
    int   last_k = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic void check(input string nm, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d] @cyc %0d: got %0d expected %0d", nm, idx, cyc, act, exp);
        end
    endfunction

    // Monitor: pops every expectation due this cycle.
    always @(negedge clk_i) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            chk_t e;
            e = sb.pop_front();
            if (e.due < cyc) begin
                check("late", e.kind, cyc, e.due);
            end else begin
                case (e.kind)
                    K_MV:   check("mv_o", e.idx, int'(mv_o[e.idx]), e.val);
                    K_CHV:  check("ch_valid_o", e.idx, int'(ch_valid_o[e.idx]), e.val);
                    K_AXX:  check("axis_x_o", 0, int'(axis_x_o), e.val);
                    K_AXY:  check("axis_y_o", 0, int'(axis_y_o), e.val);
                    K_LVL:  check("btn_level_o", e.idx, int'(btn_level_o[e.idx]), e.val);
                    K_PRS:  check("btn_press_o", e.idx, int'(btn_press_o[e.idx]), e.val);
                    default: check("all_zero", 0,
                        int'(|{mv_o, ch_valid_o, btn_level_o, btn_press_o, axis_x_o, axis_y_o}), 0);
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic expect_at(input int due, input int kind, input int idx, input int val);
        int i;
        chk_t e;
        e = '{due, kind, idx, val};
        i = 0;
        while (i < sb.size() && sb[i].due <= due) i++;
        sb.insert(i, e);
    endtask

    task automatic send(input int ch, input int code);
        resp_valid_i   = 1'b1;
        resp_channel_i = ch[ChWidth-1:0];
        resp_data_i    = code[AdcWidth-1:0];
        last_k         = cyc;
        tick();
    endtask

    task automatic idle(input int n);
        resp_valid_i = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        // Reset with traffic present: nothing may survive release.
        reset_i        = 1'b1;
        resp_valid_i   = 1'b1;
        resp_channel_i = 5'd1;
        resp_data_i    = 12'd4095;
        repeat (2) tick();
        reset_i      = 1'b0;
        resp_valid_i = 1'b0;
        expect_at(cyc, K_ALL0, 0, 0);
        expect_at(cyc + 4, K_ALL0, 0, 0);
        idle(5);

        // Stick X full scale.
        for (int s = 0; s < 4; s++) begin
            send(1, 4095);
            if (s == 2) expect_at(last_k + 3, K_CHV, 0, 0);
        end
        expect_at(last_k + 3, K_MV, 0, 4999);
        expect_at(last_k + 3, K_CHV, 0, 1);
        expect_at(last_k + 4, K_AXX, 0, 1);
        idle(6);

        // Stick Y: centred average, then below the dead zone.
        send(5, 0); send(5, 0); send(5, 4095); send(5, 4095);
        expect_at(last_k + 3, K_MV, 4, 2499);
        expect_at(last_k + 4, K_AXY, 0, 0);
        for (int s = 0; s < 4; s++) send(5, 819);
        expect_at(last_k + 3, K_MV, 4, 999);
        expect_at(last_k + 4, K_AXY, 0, 3);
        idle(6);

        // Button B: press, hold within hysteresis, release.
        for (int w = 0; w < 4; w++) begin
            for (int s = 0; s < 4; s++) send(2, 0);
            if (w == 2) expect_at(last_k + 4, K_LVL, 0, 0);
        end
        expect_at(last_k + 3, K_MV, 1, 0);
        expect_at(last_k + 4, K_LVL, 0, 1);
        expect_at(last_k + 4, K_PRS, 0, 1);
        expect_at(last_k + 5, K_PRS, 0, 0);
        expect_at(last_k + 5, K_LVL, 0, 1);
        for (int s = 0; s < 16; s++) send(2, 1065);
        expect_at(last_k + 3, K_MV, 1, 1300);
        expect_at(last_k + 4, K_LVL, 0, 1);
        expect_at(last_k + 4, K_PRS, 0, 0);
        for (int w = 0; w < 4; w++) begin
            for (int s = 0; s < 4; s++) send(2, 4095);
            if (w == 2) expect_at(last_k + 4, K_LVL, 0, 1);
        end
        expect_at(last_k + 3, K_MV, 1, 4999);
        expect_at(last_k + 4, K_LVL, 0, 0);
        expect_at(last_k + 4, K_PRS, 0, 0);
        idle(6);

        // Out-of-range channels interleaved with ch3.
        send(3, 2048); send(0, 4095); send(3, 2048); send(6, 0);
        send(3, 4095); send(31, 0); send(3, 0);
        expect_at(last_k + 3, K_MV, 2, 2499);
        expect_at(last_k + 3, K_MV, 0, 4999);
        expect_at(last_k + 3, K_MV, 4, 999);
        idle(6);

        // Reset mid-window on ch4: partial sum and in-flight samples discarded.
        send(4, 4095); send(4, 4095);
        reset_i      = 1'b1;
        resp_valid_i = 1'b0;
        tick();
        reset_i = 1'b0;
        expect_at(cyc, K_ALL0, 0, 0);
        for (int s = 0; s < 4; s++) begin
            send(4, 0);
            if (s == 1) expect_at(last_k + 3, K_CHV, 3, 0);
        end
        expect_at(last_k + 3, K_MV, 3, 0);
        expect_at(last_k + 3, K_CHV, 3, 1);
        idle(8);

        for (int t = 0; t < 100 && sb.size() > 0; t++) tick();
        if (sb.size() > 0) check("scoreboard_drain", 0, sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
